machine_phase_gen: RTL and testbench
====================================

Name: machine_phase_gen

Overview:
- Parametrised machine-cycle phase generator for the D3-28 core.
- Successor to the fixed 10-phase clock block. It divides xtal_clk into N_PHASES one-hot, active-low phase strobes tn, plus ROM, RAS and column-address windows.
- Adds run, single-step and halt control, so the ucode ROM, ALU, RAM and IO blocks can be stopped or advanced one machine cycle at a time.

Parameters:
N_PHASES, 10, number of phases per machine cycle (>=2)
DIV, 2, xtal_clk cycles per phase (>=1)
ROM_FIRST, 1, first phase with t_romn low
ROM_LAST, 2, last phase with t_romn low
RAS_FIRST, 3, first phase with t_RASn low
RAS_LAST, 8, last phase with t_RASn low
COL_PHASE, 5, first phase with A_stolb high (high through N_PHASES)
CNT_W, 16, width of cycle_cnt

Ports:
xtal_clk  in  1  system clock
init_n  in  1  synchronous reset, active-low
run  in  1  1 = free-run successive machine cycles
step_req  in  1  rising edge requests exactly one machine cycle while run=0
halt_req  in  1  level; while 1, no new machine cycle starts
tn  out  N_PHASES  phase strobes [N_PHASES:1], active-low, at most one low
t_romn  out  1  ROM access window, active-low
t_RASn  out  1  RAM row strobe, active-low
A_stolb  out  1  column-address select, active-high
cycle_end  out  1  one-clock pulse on the final xtal_clk of each machine cycle
running  out  1  1 while in ACTIVE
cycle_cnt  out  CNT_W  completed machine cycles, wraps modulo 2^CNT_W

Behaviour:
- Reset: init_n=0 sampled on a rising edge gives:
  - state IDLE;
  - tn all 1; t_romn=1, t_RASn=1, A_stolb=0;
  - cycle_end=0, running=0, cycle_cnt=0;
  - phase=1, sub=0, step_prev=1, so a step_req held high through reset does not fire.
- Reset mid-cycle aborts the cycle immediately: no cycle_end, no count.
- All outputs are registered and updated on the same edge as the state, so they are glitch-free.
- Internal counters: sub runs 0..DIV-1; phase runs 1..N_PHASES. Phase advances when sub=DIV-1.
- State IDLE:
  - All strobes inactive.
  - If halt_req=0 and run=1: go to ACTIVE with phase=1, sub=0. tn[1] goes low on that same edge, i.e. 1 clock of latency.
  - Else if halt_req=0, run=0 and a step edge is present (step_req=1, step_prev=0): go to ACTIVE in one-shot mode.
- State ACTIVE:
  - tn[p]=0 only for p=phase.
  - t_romn=0 iff ROM_FIRST<=phase<=ROM_LAST.
  - t_RASn=0 iff RAS_FIRST<=phase<=RAS_LAST.
  - A_stolb=1 iff phase>=COL_PHASE.
  - running=1.
- End of cycle (last tick: phase=N_PHASES, sub=DIV-1):
  - cycle_end=1 for that one clock.
  - cycle_cnt increments on the following edge.
  - If run=1, halt_req=0 and not one-shot: phase wraps to 1, so tn[1] follows tn[N_PHASES] with no gap.
  - Otherwise: go to IDLE.
- A started cycle always completes: run dropping, halt_req rising, or step_req toggling mid-cycle do not truncate it.
- step_prev tracks step_req every clock. Edges arriving during ACTIVE are discarded, not queued.
- Simultaneous run=1 and step edge in IDLE: free-run starts and the step edge is consumed.
- halt_req=1 with run=1 in IDLE: stays IDLE. When halt_req is released, free-run resumes the next clock.
- cycle_cnt wraps from 2^CNT_W-1 to 0 without any flag.
- Parameter legality is checked at elaboration; violations are fatal:
  - ROM_FIRST<=ROM_LAST;
  - RAS_FIRST<=RAS_LAST;
  - all window bounds and COL_PHASE within 1..N_PHASES.
- Machine cycle length is N_PHASES*DIV clocks; defaults give 20.

Test Plan:
- Reset then run=1 (defaults) -> tn[1] low 1 clock after run sampled; each tn[k] low for exactly 2 clocks in order 1..10; t_romn low for clocks 1-4 of the cycle; t_RASn low for clocks 5-16; A_stolb high for clocks 9-20; cycle_end pulses on clock 20; cycle_cnt=1 afterwards; tn[1] low again on clock 21.
- run=0, single step_req pulse -> exactly one 20-clock cycle, then IDLE with all tn=1; step_req held high 50 clocks -> still only one cycle; second edge -> cycle_cnt=2.
- Free-run, drop run at phase 4 -> cycle completes through tn[10]; IDLE on next clock; cycle_cnt +1 only.
- Free-run with halt_req=1 raised mid-cycle -> cycle completes and generator stays IDLE; halt_req=0 -> restart 1 clock later.
- init_n=0 at phase 6 -> all strobes inactive on that edge, cycle_cnt=0, no cycle_end; step_req high through reset release -> no cycle starts.
- CNT_W=4, N_PHASES=4, DIV=1, 16 cycles of free-run -> cycle_cnt wraps 15->0; tn one-hot 4-phase with no gaps between cycles.

Source files
------------

// File: rtl/machine_phase_gen.sv
// ============================================================================
// machine_phase_gen : parametrised one-hot machine-cycle phase generator with
//                     run / single-step / halt control.       Rev 1.0
// ============================================================================
`default_nettype none

module machine_phase_gen #(
  parameter int N_PHASES  = 10,
  parameter int DIV       = 2,
  parameter int ROM_FIRST = 1,
  parameter int ROM_LAST  = 2,
  parameter int RAS_FIRST = 3,
  parameter int RAS_LAST  = 8,
  parameter int COL_PHASE = 5,
  parameter int CNT_W     = 16
) (
  input  logic              xtal_clk,
  input  logic              init_n,
  input  logic              run,
  input  logic              step_req,
  input  logic              halt_req,
  output logic [N_PHASES:1] tn,
  output logic              t_romn,
  output logic              t_RASn,
  output logic              A_stolb,
  output logic              cycle_end,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int PW = $clog2(N_PHASES + 1);
  localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PH_FIRST = PW'(1);
  localparam logic [PW-1:0] PH_LAST  = PW'(N_PHASES);
  localparam logic [SW-1:0] SUB_LAST = SW'(DIV - 1);

  if (N_PHASES < 2 || DIV < 1 || ROM_FIRST > ROM_LAST || RAS_FIRST > RAS_LAST ||
      ROM_FIRST < 1 || ROM_LAST > N_PHASES || RAS_FIRST < 1 || RAS_LAST > N_PHASES ||
      COL_PHASE < 1 || COL_PHASE > N_PHASES) begin : g_bad_params
    $fatal(1, "machine_phase_gen: illegal parameter set");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   phase, phase_nxt;
  logic [SW-1:0]   sub, sub_nxt;
  logic            one_shot, one_shot_nxt;
  logic            step_prev;
  logic            cnt_inc;
  logic            step_edge;
  logic            last_tick;
  logic            act_nxt;
  logic [N_PHASES:1] tn_nxt;

  assign step_edge = step_req & ~step_prev;
  assign last_tick = (phase == PH_LAST) && (sub == SUB_LAST);

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    sub_nxt      = sub;
    one_shot_nxt = one_shot;
    cnt_inc      = 1'b0;
    case (state)
      IDLE: begin
        // run wins over a simultaneous step edge; the edge is simply consumed
        if (!halt_req && run) begin
          state_nxt    = ACTIVE;
          phase_nxt    = PH_FIRST;
          sub_nxt      = '0;
          one_shot_nxt = 1'b0;
        end else if (!halt_req && step_edge) begin
          state_nxt    = ACTIVE;
          phase_nxt    = PH_FIRST;
          sub_nxt      = '0;
          one_shot_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (last_tick) begin
          cnt_inc   = 1'b1;
          phase_nxt = PH_FIRST;
          sub_nxt   = '0;
          if (!(run && !halt_req && !one_shot)) begin
            state_nxt    = IDLE;
            one_shot_nxt = 1'b0;
          end
        end else if (sub == SUB_LAST) begin
          phase_nxt = phase + PW'(1);
          sub_nxt   = '0;
        end else begin
          sub_nxt = sub + SW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign act_nxt = (state_nxt == ACTIVE);

  for (genvar k = 1; k <= N_PHASES; k++) begin : g_tn
    assign tn_nxt[k] = ~(act_nxt && (phase_nxt == PW'(k)));
  end

  // Strobes are computed from the next-state values so they land on the same edge.
  always_ff @(posedge xtal_clk) begin
    if (!init_n) begin
      state     <= IDLE;
      phase     <= PH_FIRST;
      sub       <= '0;
      one_shot  <= 1'b0;
      step_prev <= 1'b1;
      tn        <= '1;
      t_romn    <= 1'b1;
      t_RASn    <= 1'b1;
      A_stolb   <= 1'b0;
      cycle_end <= 1'b0;
      running   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      sub       <= sub_nxt;
      one_shot  <= one_shot_nxt;
      step_prev <= step_req;
      tn        <= tn_nxt;
      t_romn    <= ~(act_nxt && (phase_nxt >= PW'(ROM_FIRST)) && (phase_nxt <= PW'(ROM_LAST)));
      t_RASn    <= ~(act_nxt && (phase_nxt >= PW'(RAS_FIRST)) && (phase_nxt <= PW'(RAS_LAST)));
      A_stolb   <= act_nxt && (phase_nxt >= PW'(COL_PHASE));
      cycle_end <= act_nxt && (phase_nxt == PH_LAST) && (sub_nxt == SUB_LAST);
      running   <= act_nxt;
      if (cnt_inc) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_machine_phase_gen.sv
// ============================================================================
// tb_machine_phase_gen : directed + randomized bench for machine_phase_gen,
//                        default instance plus a 4-phase wrap instance. Rev 1.0
// ============================================================================
`default_nettype none

module tb_machine_phase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: defaults; instance 1: N_PHASES=4, DIV=1, CNT_W=4
  logic        init_n_a, run_a, step_a, halt_a;
  logic [10:1] tn_a;
  logic        romn_a, rasn_a, stolb_a, cend_a, running_a;
  logic [15:0] cnt_a;

  logic        init_n_b, run_b, step_b, halt_b;
  logic [4:1]  tn_b;
  logic        romn_b, rasn_b, stolb_b, cend_b, running_b;
  logic [3:0]  cnt_b;

  machine_phase_gen dut_a (
    .xtal_clk(clk), .init_n(init_n_a), .run(run_a), .step_req(step_a), .halt_req(halt_a),
    .tn(tn_a), .t_romn(romn_a), .t_RASn(rasn_a), .A_stolb(stolb_a),
    .cycle_end(cend_a), .running(running_a), .cycle_cnt(cnt_a)
  );

  machine_phase_gen #(
    .N_PHASES(4), .DIV(1), .ROM_FIRST(1), .ROM_LAST(1), .RAS_FIRST(2), .RAS_LAST(3),
    .COL_PHASE(3), .CNT_W(4)
  ) dut_b (
    .xtal_clk(clk), .init_n(init_n_b), .run(run_b), .step_req(step_b), .halt_req(halt_b),
    .tn(tn_b), .t_romn(romn_b), .t_RASn(rasn_b), .A_stolb(stolb_b),
    .cycle_end(cend_b), .running(running_b), .cycle_cnt(cnt_b)
  );

  // Reference model: a cycle is a run of N_PHASES*DIV clocks indexed by pos.
  int NP[2] = '{10, 4};
  int DV[2] = '{2, 1};
  int RF[2] = '{1, 1};
  int RL[2] = '{2, 1};
  int AF[2] = '{3, 2};
  int AL[2] = '{8, 3};
  int CP[2] = '{5, 3};
  int CW[2] = '{16, 4};

  bit m_act[2];
  int m_pos[2];
  bit m_os[2];
  int m_cnt[2];
  bit m_prev[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input int i, input logic rn, input logic r, input logic s, input logic h);
    bit edge_s;
    if (!rn) begin
      m_act[i] = 0; m_pos[i] = 0; m_os[i] = 0; m_cnt[i] = 0; m_prev[i] = 1;
    end else begin
      edge_s = s && !m_prev[i];
      if (!m_act[i]) begin
        if (!h && r) begin
          m_act[i] = 1; m_pos[i] = 0; m_os[i] = 0;
        end else if (!h && edge_s) begin
          m_act[i] = 1; m_pos[i] = 0; m_os[i] = 1;
        end
      end else if (m_pos[i] == NP[i] * DV[i] - 1) begin
        m_cnt[i] = (m_cnt[i] + 1) % (1 << CW[i]);
        if (r && !h && !m_os[i]) m_pos[i] = 0;
        else m_act[i] = 0;
      end else begin
        m_pos[i]++;
      end
      m_prev[i] = s;
    end
  endtask

  task automatic check_inst(input int i, input logic [31:0] tn_o, input logic [2:0] win_o,
                            input logic ce_o, input logic run_o, input logic [31:0] cnt_o);
    int ph;
    logic [31:0] ones, exp_tn;
    logic [2:0] exp_win;
    ph     = m_pos[i] / DV[i] + 1;
    ones   = (32'd1 << NP[i]) - 32'd1;
    exp_tn = m_act[i] ? (ones & ~(32'd1 << (ph - 1))) : ones;
    exp_win[2] = !(m_act[i] && ph >= RF[i] && ph <= RL[i]);
    exp_win[1] = !(m_act[i] && ph >= AF[i] && ph <= AL[i]);
    exp_win[0] = m_act[i] && ph >= CP[i];
    check($sformatf("tn_%0d", i), tn_o, exp_tn);
    check($sformatf("windows_%0d", i), {29'd0, win_o}, {29'd0, exp_win});
    check($sformatf("cycle_end_%0d", i), {31'd0, ce_o},
          {31'd0, m_act[i] && (m_pos[i] == NP[i] * DV[i] - 1)});
    check($sformatf("running_%0d", i), {31'd0, run_o}, {31'd0, m_act[i]});
    check($sformatf("cycle_cnt_%0d", i), cnt_o, m_cnt[i]);
  endtask

  // Inputs change only at posedge+1, so the model sees exactly what the DUT sampled.
  task automatic tick();
    @(posedge clk);
    model_step(0, init_n_a, run_a, step_a, halt_a);
    model_step(1, init_n_b, run_b, step_b, halt_b);
    #1;
    check_inst(0, {22'd0, tn_a}, {romn_a, rasn_a, stolb_a}, cend_a, running_a, {16'd0, cnt_a});
    check_inst(1, {28'd0, tn_b}, {romn_b, rasn_b, stolb_b}, cend_b, running_b, {28'd0, cnt_b});
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int c0;
    init_n_a = 0; run_a = 0; step_a = 1; halt_a = 0;
    init_n_b = 0; run_b = 0; step_b = 0; halt_b = 0;
    ticks(3);
    check("reset_tn", {22'd0, tn_a}, 32'h3FF);
    check("reset_cnt", {16'd0, cnt_a}, 32'd0);

    // step held high across reset release must not fire
    init_n_a = 1; init_n_b = 1; run_b = 1;
    ticks(5);
    check("step_through_reset", {31'd0, running_a}, 32'd0);
    step_a = 0;
    tick();

    // free-run: first strobe one clock after run is sampled
    run_a = 1;
    tick();
    check("run_latency_tn1", {22'd0, tn_a}, 32'h3FE);
    ticks(44);

    // drop run at phase 4; cycle must finish and count once
    for (int n = 0; n < 40 && !(m_act[0] && m_pos[0] == 6); n++) tick();
    check("reach_phase4", {22'd0, tn_a}, 32'h3F7);
    c0 = m_cnt[0];
    run_a = 0;
    for (int n = 0; n < 40 && running_a; n++) tick();
    check("drop_run_idle", {31'd0, running_a}, 32'd0);
    check("drop_run_cnt", {16'd0, cnt_a}, c0 + 1);
    ticks(3);

    // single step pulse, then a long held step, then a second edge
    c0 = m_cnt[0];
    step_a = 1; tick(); step_a = 0;
    ticks(25);
    check("one_step_cnt", {16'd0, cnt_a}, c0 + 1);
    step_a = 1; ticks(50); step_a = 0;
    check("held_step_cnt", {16'd0, cnt_a}, c0 + 2);
    tick(); step_a = 1; ticks(25); step_a = 0;
    check("second_edge_cnt", {16'd0, cnt_a}, c0 + 3);
    check("step_done_tn", {22'd0, tn_a}, 32'h3FF);

    // halt raised mid-cycle: finish, stay idle, restart one clock after release
    run_a = 1; ticks(8);
    halt_a = 1; ticks(40);
    check("halt_idle", {31'd0, running_a}, 32'd0);
    halt_a = 0; tick();
    check("halt_release_tn1", {22'd0, tn_a}, 32'h3FE);

    // reset at phase 6 aborts the cycle
    for (int n = 0; n < 40 && !(m_act[0] && m_pos[0] == 10); n++) tick();
    check("reach_phase6", {22'd0, tn_a}, 32'h3DF);
    init_n_a = 0; step_a = 1; tick();
    check("abort_tn", {22'd0, tn_a}, 32'h3FF);
    check("abort_cend", {31'd0, cend_a}, 32'd0);
    check("abort_cnt", {16'd0, cnt_a}, 32'd0);
    run_a = 0; init_n_a = 1; ticks(5);
    check("abort_step_held", {31'd0, running_a}, 32'd0);
    step_a = 0;

    // randomized control traffic on both instances
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 19) == 0) run_a = ~run_a;
      if ($urandom_range(0, 24) == 0) halt_a = ~halt_a;
      if ($urandom_range(0, 7) == 0) step_a = ~step_a;
      init_n_a = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 29) == 0) halt_b = ~halt_b;
      step_b = $urandom_range(0, 1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
